// File: rtl/up_param_core.sv
// Parametrised two-phase accumulator microprocessor core with RAM paging,
// compare-immediate and a hardware return stack for CALL/RET.
module up_param_core #(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 12,
   parameter int unsigned SD = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW+3:0] program_byte,
   input  logic [DW-1:0] pushbuttons,
   input  logic [DW-1:0] ram_rdata,
   output logic [AW-1:0] PC,
   output logic [AW-1:0] address_RAM,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   output logic          phase,
   output logic [3:0]    instr,
   output logic [DW-1:0] oprnd,
   output logic [DW-1:0] accu,
   output logic          c_flag,
   output logic          z_flag,
   output logic [DW-1:0] FF_out,
   output logic          stk_err
);

   localparam int unsigned PGW   = AW - DW;
   localparam int unsigned SPW   = $clog2(SD + 1);
   localparam int unsigned IW    = (SD > 1) ? $clog2(SD) : 1;
   localparam int unsigned DEPTH = 1 << IW;

   typedef enum logic {PH_FETCH = 1'b0, PH_EXEC = 1'b1} phase_e;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,  OP_LIT  = 4'd1,  OP_LD   = 4'd2,  OP_ST   = 4'd3,
      OP_IN   = 4'd4,  OP_OUT  = 4'd5,  OP_ADDI = 4'd6,  OP_ADDM = 4'd7,
      OP_NANDI= 4'd8,  OP_LDP  = 4'd9,  OP_CMPI = 4'd10, OP_JC   = 4'd11,
      OP_JZ   = 4'd12, OP_JMP  = 4'd13, OP_CALL = 4'd14, OP_RET  = 4'd15
   } op_e;

   phase_e          phase_q, phase_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [PGW-1:0]  pg_q, pg_d;
   logic [DW-1:0]   accu_q, accu_d;
   logic [DW-1:0]   ff_q, ff_d;
   logic [3:0]      instr_q, instr_d;
   logic [DW-1:0]   oprnd_q, oprnd_d;
   logic            c_q, c_d;
   logic            z_q, z_d;
   logic            err_q, err_d;
   logic [SPW-1:0]  sp_q, sp_d;
   logic [AW-1:0]   stk_q [DEPTH];

   logic            push_c;
   logic [AW-1:0]   target_c;
   logic [AW-1:0]   pg_shift_c;
   logic [DW:0]     sum_c;

   assign target_c   = {pg_q, oprnd_q};
   assign pg_shift_c = {pg_q, DW'(0)} | AW'(oprnd_q);

   // Next-state logic: fetch latches the instruction, execute performs it
   always_comb begin
      phase_d = phase_q;
      pc_d    = pc_q;
      pg_d    = pg_q;
      accu_d  = accu_q;
      ff_d    = ff_q;
      instr_d = instr_q;
      oprnd_d = oprnd_q;
      c_d     = c_q;
      z_d     = z_q;
      err_d   = err_q;
      sp_d    = sp_q;
      push_c  = 1'b0;
      sum_c   = '0;

      if (phase_q == PH_FETCH) begin
         instr_d = program_byte[DW+3:DW];
         oprnd_d = program_byte[DW-1:0];
         pc_d    = pc_q + AW'(1);
         phase_d = PH_EXEC;
      end else begin
         phase_d = PH_FETCH;
         case (op_e'(instr_q))
            OP_LIT: begin
               accu_d = oprnd_q;
               z_d    = (oprnd_q == '0);
            end
            OP_LD: begin
               accu_d = ram_rdata;
               z_d    = (ram_rdata == '0);
            end
            OP_IN: begin
               accu_d = pushbuttons;
               z_d    = (pushbuttons == '0);
            end
            OP_OUT: ff_d = accu_q;
            OP_ADDI, OP_ADDM: begin
               sum_c  = {1'b0, accu_q} +
                        {1'b0, (instr_q == OP_ADDI) ? oprnd_q : ram_rdata};
               accu_d = sum_c[DW-1:0];
               c_d    = sum_c[DW];
               z_d    = (sum_c[DW-1:0] == '0);
            end
            OP_NANDI: begin
               accu_d = ~(accu_q & oprnd_q);
               z_d    = ((accu_q & oprnd_q) == '1);
            end
            OP_LDP: pg_d = pg_shift_c[PGW-1:0];
            OP_CMPI: begin
               c_d = (accu_q < oprnd_q);
               z_d = (accu_q == oprnd_q);
            end
            OP_JC:  if (c_q) pc_d = target_c;
            OP_JZ:  if (z_q) pc_d = target_c;
            OP_JMP: pc_d = target_c;
            OP_CALL: begin
               if (sp_q == SPW'(SD)) begin
                  err_d = 1'b1;
               end else begin
                  push_c = 1'b1;
                  sp_d   = sp_q + SPW'(1);
                  pc_d   = target_c;
               end
            end
            OP_RET: begin
               if (sp_q == '0) begin
                  err_d = 1'b1;
               end else begin
                  sp_d = sp_q - SPW'(1);
                  pc_d = stk_q[IW'(sp_q - SPW'(1))];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= PH_FETCH;
         pc_q    <= '0;
         pg_q    <= '0;
         accu_q  <= '0;
         ff_q    <= '0;
         instr_q <= '0;
         oprnd_q <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
         sp_q    <= '0;
      end else begin
         phase_q <= phase_d;
         pc_q    <= pc_d;
         pg_q    <= pg_d;
         accu_q  <= accu_d;
         ff_q    <= ff_d;
         instr_q <= instr_d;
         oprnd_q <= oprnd_d;
         c_q     <= c_d;
         z_q     <= z_d;
         err_q   <= err_d;
         sp_q    <= sp_d;
      end
   end

   // Return addresses need no reset: the pointer alone defines validity
   always_ff @(posedge clock) begin
      if (push_c && !reset) stk_q[IW'(sp_q)] <= pc_q;
   end

   assign PC          = pc_q;
   assign address_RAM = {pg_q, oprnd_q};
   assign ram_wdata   = accu_q;
   assign ram_we      = (phase_q == PH_EXEC) && (instr_q == OP_ST) && !reset;
   assign phase       = phase_q;
   assign instr       = instr_q;
   assign oprnd       = oprnd_q;
   assign accu        = accu_q;
   assign c_flag      = c_q;
   assign z_flag      = z_q;
   assign FF_out      = ff_q;
   assign stk_err     = err_q;

endmodule

// File: tb/tb_up_param_core.sv
// Bench for up_param_core: instruction table with scoreboard on a DW=4/AW=12/SD=2
// core, plus hand sequences for reset-in-execute and a DW=8/AW=16 build.
module tb_up_param_core;

   logic        clock = 1'b0;
   logic        reset;
   always #5 clock = ~clock;

   logic [7:0]  program_byte;
   logic [3:0]  pushbuttons, ram_rdata;
   logic [11:0] PC, address_RAM;
   logic [3:0]  ram_wdata, instr, oprnd, accu, FF_out;
   logic        ram_we, phase, c_flag, z_flag, stk_err;

   up_param_core #(.DW(4), .AW(12), .SD(2)) dut (
      .clock(clock), .reset(reset), .program_byte(program_byte),
      .pushbuttons(pushbuttons), .ram_rdata(ram_rdata), .PC(PC),
      .address_RAM(address_RAM), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .phase(phase), .instr(instr), .oprnd(oprnd), .accu(accu),
      .c_flag(c_flag), .z_flag(z_flag), .FF_out(FF_out), .stk_err(stk_err)
   );

   logic [11:0] pb8;
   logic [7:0]  pbut8, rd8, wd8, op8, acc8, ff8;
   logic [15:0] pc8, addr8;
   logic        we8, ph8, c8, z8, err8;
   logic [3:0]  ins8;

   assign pbut8 = 8'h00;
   assign rd8   = 8'h00;

   up_param_core #(.DW(8), .AW(16), .SD(4)) dut8 (
      .clock(clock), .reset(reset), .program_byte(pb8),
      .pushbuttons(pbut8), .ram_rdata(rd8), .PC(pc8),
      .address_RAM(addr8), .ram_wdata(wd8), .ram_we(we8),
      .phase(ph8), .instr(ins8), .oprnd(op8), .accu(acc8),
      .c_flag(c8), .z_flag(z8), .FF_out(ff8), .stk_err(err8)
   );

   // Data RAM model: combinational read, write on the clock edge
   logic [3:0] ram [4096];
   assign ram_rdata = ram[address_RAM];
   always @(posedge clock) if (ram_we) ram[address_RAM] <= ram_wdata;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  opd;
      logic [3:0]  a;
      logic        c;
      logic        z;
      logic [11:0] pc;
      logic [3:0]  ff;
      logic        err;
      logic [11:0] addr;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void add(input logic [3:0] op, input logic [3:0] opd,
                               input logic [3:0] a, input logic c, input logic z,
                               input logic [11:0] pc, input logic [3:0] ff,
                               input logic err, input logic [11:0] addr);
      vec_t v;
      v.op = op; v.opd = opd; v.a = a; v.c = c; v.z = z;
      v.pc = pc; v.ff = ff; v.err = err; v.addr = addr;
      tbl.push_back(v);
   endfunction

   // One instruction: drive at fetch, check execute-phase strobes, then retire
   task automatic run_vec(input int idx, input vec_t v);
      vec_t e;
      program_byte = {v.op, v.opd};
      sb.push_back(v);
      @(posedge clock); #1;
      chk($sformatf("v%0d exec phase", idx), 32'(phase), 32'd1);
      chk($sformatf("v%0d instr", idx), 32'(instr), 32'(v.op));
      chk($sformatf("v%0d oprnd", idx), 32'(oprnd), 32'(v.opd));
      chk($sformatf("v%0d ram_we exec", idx), 32'(ram_we), 32'(v.op == 4'd3));
      if (v.op == 4'd3) begin
         chk($sformatf("v%0d st addr", idx), 32'(address_RAM), 32'(v.addr));
         chk($sformatf("v%0d st wdata", idx), 32'(ram_wdata), 32'(v.a));
      end
      @(posedge clock); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d accu", idx), 32'(accu), 32'(e.a));
      chk($sformatf("v%0d c_flag", idx), 32'(c_flag), 32'(e.c));
      chk($sformatf("v%0d z_flag", idx), 32'(z_flag), 32'(e.z));
      chk($sformatf("v%0d PC", idx), 32'(PC), 32'(e.pc));
      chk($sformatf("v%0d FF_out", idx), 32'(FF_out), 32'(e.ff));
      chk($sformatf("v%0d stk_err", idx), 32'(stk_err), 32'(e.err));
      chk($sformatf("v%0d fetch phase", idx), 32'(phase), 32'd0);
      chk($sformatf("v%0d ram_we fetch", idx), 32'(ram_we), 32'd0);
   endtask

   task automatic run8(input logic [3:0] op, input logic [7:0] opd);
      pb8 = {op, opd};
      @(posedge clock); #1;
      @(posedge clock); #1;
   endtask

   initial begin
      //   op    opd   A     C  Z  PC      FF    E  addr
      add(4'd1, 4'h5, 4'h5, 0, 0, 12'h001, 4'h0, 0, 12'h0);   // LIT 5
      add(4'd5, 4'h0, 4'h5, 0, 0, 12'h002, 4'h5, 0, 12'h0);   // OUT
      add(4'd1, 4'hF, 4'hF, 0, 0, 12'h003, 4'h5, 0, 12'h0);   // LIT F
      add(4'd6, 4'h1, 4'h0, 1, 1, 12'h004, 4'h5, 0, 12'h0);   // ADDI 1
      add(4'd1, 4'h2, 4'h2, 1, 0, 12'h005, 4'h5, 0, 12'h0);   // LIT 2
      add(4'd10,4'h3, 4'h2, 1, 0, 12'h006, 4'h5, 0, 12'h0);   // CMPI 3
      add(4'd10,4'h2, 4'h2, 0, 1, 12'h007, 4'h5, 0, 12'h0);   // CMPI 2
      add(4'd8, 4'h6, 4'hD, 0, 0, 12'h008, 4'h5, 0, 12'h0);   // NANDI 6
      add(4'd4, 4'h0, 4'h9, 0, 0, 12'h009, 4'h5, 0, 12'h0);   // IN
      add(4'd6, 4'h9, 4'h2, 1, 0, 12'h00A, 4'h5, 0, 12'h0);   // ADDI 9
      add(4'd9, 4'hA, 4'h2, 1, 0, 12'h00B, 4'h5, 0, 12'h0);   // LDP A
      add(4'd9, 4'hB, 4'h2, 1, 0, 12'h00C, 4'h5, 0, 12'h0);   // LDP B
      add(4'd1, 4'h7, 4'h7, 1, 0, 12'h00D, 4'h5, 0, 12'h0);   // LIT 7
      add(4'd3, 4'h3, 4'h7, 1, 0, 12'h00E, 4'h5, 0, 12'hAB3); // ST 3
      add(4'd1, 4'h0, 4'h0, 1, 1, 12'h00F, 4'h5, 0, 12'h0);   // LIT 0
      add(4'd2, 4'h3, 4'h7, 1, 0, 12'h010, 4'h5, 0, 12'h0);   // LD 3
      add(4'd7, 4'h3, 4'hE, 0, 0, 12'h011, 4'h5, 0, 12'h0);   // ADDM 3
      add(4'd7, 4'h3, 4'h5, 1, 0, 12'h012, 4'h5, 0, 12'h0);   // ADDM 3
      add(4'd11,4'h5, 4'h5, 1, 0, 12'hAB5, 4'h5, 0, 12'h0);   // JC 5 taken
      add(4'd9, 4'h0, 4'h5, 1, 0, 12'hAB6, 4'h5, 0, 12'h0);   // LDP 0
      add(4'd9, 4'h0, 4'h5, 1, 0, 12'hAB7, 4'h5, 0, 12'h0);   // LDP 0
      add(4'd9, 4'h1, 4'h5, 1, 0, 12'hAB8, 4'h5, 0, 12'h0);   // LDP 1
      add(4'd1, 4'h0, 4'h0, 1, 1, 12'hAB9, 4'h5, 0, 12'h0);   // LIT 0
      add(4'd12,4'h2, 4'h0, 1, 1, 12'h012, 4'h5, 0, 12'h0);   // JZ taken
      add(4'd1, 4'h1, 4'h1, 1, 0, 12'h013, 4'h5, 0, 12'h0);   // LIT 1
      add(4'd12,4'h4, 4'h1, 1, 0, 12'h014, 4'h5, 0, 12'h0);   // JZ untaken
      add(4'd10,4'h0, 4'h1, 0, 0, 12'h015, 4'h5, 0, 12'h0);   // CMPI 0
      add(4'd11,4'h9, 4'h1, 0, 0, 12'h016, 4'h5, 0, 12'h0);   // JC untaken
      add(4'd13,4'h2, 4'h1, 0, 0, 12'h012, 4'h5, 0, 12'h0);   // JMP 2
      add(4'd14,4'h8, 4'h1, 0, 0, 12'h018, 4'h5, 0, 12'h0);   // CALL
      add(4'd14,4'hA, 4'h1, 0, 0, 12'h01A, 4'h5, 0, 12'h0);   // CALL
      add(4'd14,4'hC, 4'h1, 0, 0, 12'h01B, 4'h5, 1, 12'h0);   // CALL full
      add(4'd15,4'h0, 4'h1, 0, 0, 12'h019, 4'h5, 1, 12'h0);   // RET
      add(4'd15,4'h0, 4'h1, 0, 0, 12'h013, 4'h5, 1, 12'h0);   // RET
      add(4'd15,4'h0, 4'h1, 0, 0, 12'h014, 4'h5, 1, 12'h0);   // RET empty
      add(4'd0, 4'h0, 4'h1, 0, 0, 12'h015, 4'h5, 1, 12'h0);   // NOP
      add(4'd9, 4'hF, 4'h1, 0, 0, 12'h016, 4'h5, 1, 12'h0);   // LDP F
      add(4'd9, 4'hF, 4'h1, 0, 0, 12'h017, 4'h5, 1, 12'h0);   // LDP F
      add(4'd13,4'hF, 4'h1, 0, 0, 12'hFFF, 4'h5, 1, 12'h0);   // JMP FFF
      add(4'd0, 4'h0, 4'h1, 0, 0, 12'h000, 4'h5, 1, 12'h0);   // NOP, PC wraps

      for (int i = 0; i < 4096; i++) ram[i] = 4'h0;
      reset        = 1'b1;
      program_byte = 8'h00;
      pb8          = 12'h000;
      pushbuttons  = 4'h9;
      repeat (2) @(posedge clock);
      #1;
      chk("rst PC", 32'(PC), 32'd0);
      chk("rst phase", 32'(phase), 32'd0);
      chk("rst accu", 32'(accu), 32'd0);
      chk("rst flags", 32'({c_flag, z_flag, stk_err}), 32'd0);
      chk("rst FF_out", 32'(FF_out), 32'd0);
      chk("rst instr/oprnd", 32'({instr, oprnd}), 32'd0);
      chk("rst address_RAM", 32'(address_RAM), 32'd0);
      chk("rst ram_we", 32'(ram_we), 32'd0);
      reset = 1'b0;

      foreach (tbl[i]) run_vec(i, tbl[i]);
      chk("ram model AB3", 32'(ram[12'hAB3]), 32'h7);

      // Reset arriving during the execute cycle of a store
      program_byte = 8'hE5; @(posedge clock); #1; @(posedge clock); #1;  // CALL 5
      chk("pre-rst CALL PC", 32'(PC), 32'hFF5);
      program_byte = 8'h13; @(posedge clock); #1; @(posedge clock); #1;  // LIT 3
      program_byte = 8'h32; @(posedge clock); #1;                         // ST 2
      chk("st exec ram_we", 32'(ram_we), 32'd1);
      reset = 1'b1; #1;
      chk("st under reset ram_we", 32'(ram_we), 32'd0);
      @(posedge clock); #1;
      chk("post-rst PC", 32'(PC), 32'd0);
      chk("post-rst phase", 32'(phase), 32'd0);
      chk("post-rst accu", 32'(accu), 32'd0);
      chk("post-rst stk_err", 32'(stk_err), 32'd0);
      chk("post-rst address_RAM", 32'(address_RAM), 32'd0);
      chk("no store at FF2", 32'(ram[12'hFF2]), 32'd0);
      reset = 1'b0;
      program_byte = 8'hF0; @(posedge clock); #1; @(posedge clock); #1;  // RET on empty
      chk("post-rst RET stk_err", 32'(stk_err), 32'd1);
      chk("post-rst RET PC", 32'(PC), 32'd1);
      program_byte = 8'h00;

      // Wide build: DW=8, AW=16
      reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
      run8(4'd1, 8'hFF);
      chk("w8 LIT accu", 32'(acc8), 32'hFF);
      chk("w8 LIT z", 32'(z8), 32'd0);
      run8(4'd6, 8'h01);
      chk("w8 ADDI accu", 32'(acc8), 32'd0);
      chk("w8 ADDI c", 32'(c8), 32'd1);
      chk("w8 ADDI z", 32'(z8), 32'd1);
      chk("w8 PC", 32'(pc8), 32'd2);
      run8(4'd9, 8'h12);
      run8(4'd13, 8'h34);
      chk("w8 JMP PC", 32'(pc8), 32'h1234);
      run8(4'd1, 8'h5A);
      run8(4'd3, 8'h66);
      chk("w8 ST addr", 32'(addr8), 32'h1266);
      chk("w8 misc", 32'({we8, ph8, err8, ins8, op8, wd8, ff8}),
          32'({1'b0, 1'b0, 1'b0, 4'd3, 8'h66, 8'h5A, 8'h00}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
